vga_pixel_tx: RTL

VGA_PIXEL_TX -- requirements
Module: vga_pixel_tx

---
 rtl/vga_pixel_tx_if.sv | 22 ++
 rtl/vga_pixel_tx.sv | 125 ++++++++++++
 2 files changed

// File: rtl/vga_pixel_tx_if.sv
// Pixel stream in, strobed luma/coordinate word and frame/drop status out.
interface vga_pixel_tx_if;
    logic        in_valid;
    logic        in_sof;
    logic [7:0]  in_r;
    logic [7:0]  in_g;
    logic [7:0]  in_b;
    logic [30:0] out_data;
    logic        frame_done;
    logic [7:0]  drop_count;
    logic [15:0] frame_count;

    modport master (
        output in_valid, in_sof, in_r, in_g, in_b,
        input  out_data, frame_done, drop_count, frame_count
    );

    modport slave (
        input  in_valid, in_sof, in_r, in_g, in_b,
        output out_data, frame_done, drop_count, frame_count
    );
endinterface

// File: rtl/vga_pixel_tx.sv
// Accepts at most one pixel every other clock, converts it to luma and launches
// {strobe, luma, X, Y} with the strobe rising one cycle after the data settles.
module vga_pixel_tx #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480
) (
    input logic            clk,
    input logic            reset,
    vga_pixel_tx_if.slave  bus
);
    localparam logic [10:0] X_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] Y_LAST = 11'(V_ACTIVE - 1);

    logic        acc_prev_q, acc_prev_d;
    logic [10:0] x_q, x_d, y_q, y_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        s1_v_q, s1_v_d;
    logic [15:0] prod_r_q, prod_r_d, prod_g_q, prod_g_d, prod_b_q, prod_b_d;
    logic [10:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    logic        s1_last_q, s1_last_d;
    logic [30:0] out_q, out_d;
    logic        done_q, done_d;

    logic        accept, drop, is_last;
    logic [10:0] x_acc, y_acc;
    logic [15:0] luma_sum;
    logic [7:0]  luma;

    always_comb begin
        accept   = bus.in_valid && !acc_prev_q;
        drop     = bus.in_valid && acc_prev_q;
        // in_sof overrides the running counters for the pixel it arrives with
        x_acc    = bus.in_sof ? '0 : x_q;
        y_acc    = bus.in_sof ? '0 : y_q;
        is_last  = (x_acc == X_LAST) && (y_acc == Y_LAST);
        luma_sum = prod_r_q + prod_g_q + prod_b_q;
        luma     = 8'(luma_sum >> 8);

        acc_prev_d  = accept;
        x_d         = x_q;
        y_d         = y_q;
        drop_cnt_d  = drop_cnt_q;
        frame_cnt_d = frame_cnt_q;
        s1_v_d      = accept;
        prod_r_d    = prod_r_q;
        prod_g_d    = prod_g_q;
        prod_b_d    = prod_b_q;
        s1_x_d      = s1_x_q;
        s1_y_d      = s1_y_q;
        s1_last_d   = s1_last_q;
        out_d       = out_q;
        done_d      = 1'b0;

        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end

        if (accept) begin
            prod_r_d  = 16'(bus.in_r) * 16'd77;
            prod_g_d  = 16'(bus.in_g) * 16'd150;
            prod_b_d  = 16'(bus.in_b) * 16'd29;
            s1_x_d    = x_acc;
            s1_y_d    = y_acc;
            s1_last_d = is_last;
            if (x_acc == X_LAST) begin
                x_d = '0;
                y_d = (y_acc == Y_LAST) ? '0 : y_acc + 11'd1;
            end else begin
                x_d = x_acc + 11'd1;
                y_d = y_acc;
            end
        end

        // Accepts are at least two cycles apart, so the strobe always gets its high cycle
        if (s1_v_q) begin
            out_d  = {1'b0, luma, s1_x_q, s1_y_q};
            done_d = s1_last_q;
            if (s1_last_q) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end else begin
            out_d = {1'b1, out_q[29:0]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_prev_q  <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            drop_cnt_q  <= '0;
            frame_cnt_q <= '0;
            s1_v_q      <= 1'b0;
            prod_r_q    <= '0;
            prod_g_q    <= '0;
            prod_b_q    <= '0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_last_q   <= 1'b0;
            out_q       <= {1'b1, 30'b0};
            done_q      <= 1'b0;
        end else begin
            acc_prev_q  <= acc_prev_d;
            x_q         <= x_d;
            y_q         <= y_d;
            drop_cnt_q  <= drop_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            s1_v_q      <= s1_v_d;
            prod_r_q    <= prod_r_d;
            prod_g_q    <= prod_g_d;
            prod_b_q    <= prod_b_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s1_last_q   <= s1_last_d;
            out_q       <= out_d;
            done_q      <= done_d;
        end
    end

    assign bus.out_data    = out_q;
    assign bus.frame_done  = done_q;
    assign bus.drop_count  = drop_cnt_q;
    assign bus.frame_count = frame_cnt_q;
endmodule
